fir_axis_engine: RTL and testbench
==================================

# fir_axis_engine

FIR compute stage sitting directly downstream of the Wishbone-to-AXI bridge. It is an AXI-Lite slave holding control, length, tap-count and coefficient registers, and it consumes X samples on an AXI-Stream slave. It computes one output per input with a single sequential multiply-accumulate (MAC) unit and returns Y samples on an AXI-Stream master, asserting tlast on the final sample.

## Interface
- MAX_TAPS, 32, size of the coefficient array and the delay line.
- wb_clk_i  in  1  clock; all logic is rising-edge.
- wb_rst_i  in  1  reset: asynchronous, active-high; clock wb_clk_i.
- awvalid/awready  in/out  1/1  AXI-Lite write-address handshake.
- awaddr  in  32  write address; only bits [7:0] are decoded.
- wvalid/wready  in/out  1/1  AXI-Lite write-data handshake.
- wdata  in  32  write data.
- wstrb  in  4  write strobes; ignored, every write is full-word.
- bvalid/bready  out/in  1/1  write-response handshake.
- arvalid/arready  in/out  1/1  read-address handshake.
- araddr  in  32  read address; bits [7:0] are decoded.
- rvalid/rready  out/in  1/1  read-data handshake.
- rdata  out  32  read data.
- ss_tvalid/ss_tready  in/out  1/1  X stream handshake.
- ss_tdata  in  32  X sample, signed.
- ss_tlast  in  1  ignored.
- sm_tvalid/sm_tready  out/in  1/1  Y stream handshake.
- sm_tdata  out  32  Y sample, signed.
- sm_tlast  out  1  final Y sample of the run.

## Operation
- Register map:
  - 0x00 ap_ctrl:
    - bit0 ap_start: write 1 to start; reads 0.
    - bit1 ap_done: read-only; cleared by a read of 0x00 (the read returns 1) and by a start.
    - bit2 ap_idle: read-only.
  - 0x10 data_length.
  - 0x14 num_taps.
  - 0x80+4k coef[k], k < MAX_TAPS.
  - Other addresses read 0; writes to them are ignored.
- Writes to 0x10, 0x14 and coef while the engine is busy (not IDLE) are dropped but still receive bvalid.
- An ap_start write while busy is ignored.
- Effective tap count is min(num_taps, MAX_TAPS).
- data_length = 0 is treated as 1.
- FSM states:
  - IDLE: ap_idle = 1. Start clears the delay line, the sample counter and ap_done, then goes to WAIT_X.
  - WAIT_X: ss_tready = 1. On handshake, shift: x[0] = ss_tdata, x[k] = x[k-1]. Clear acc and k, then go to MAC. If the effective tap count is 0, go to OUT with acc = 0.
  - MAC: each cycle acc += coef[k]*x[k], then k++. After the last tap, go to OUT.
  - OUT: sm_tvalid = 1. sm_tlast = 1 when the sample counter equals data_length-1. On handshake: if last, set ap_done and go to IDLE; otherwise increment the counter and go to WAIT_X.
- Arithmetic:
  - Operands are signed 32-bit; each product is signed 64-bit.
  - acc is 32-bit and keeps the low 32 bits of the running sum, wrapping on overflow; it does not saturate.
- Delay line entries not yet written read as 0.

## Timing
- Reset values:
  - awready, wready, arready, bvalid, rvalid, ss_tready, sm_tvalid, sm_tlast: 0.
  - rdata, sm_tdata: 0.
  - State IDLE; ap_done 0; ap_idle 1; all registers 0.
- AXI-Lite write:
  - awvalid and wvalid both high for cycle t → awready and wready pulse high for exactly one cycle at t+1, and the register is updated at that edge.
  - bvalid is high from t+2 until bready is sampled high.
  - No new write is accepted while bvalid = 1.
  - Readies are registered and never combinationally depend on the valids.
- AXI-Lite read:
  - arvalid at t → arready pulses high at t+1.
  - rvalid and rdata are high from t+2 and held stable until rready.
- A simultaneous read and write are both served; there is no ordering dependency.
- Stream latency: an X handshake at cycle t → sm_tvalid at t+N+1, where N is the effective tap count.
- While sm_tvalid = 1 and sm_tready = 0, sm_tdata and sm_tlast hold.
- ss_tready is low in every state except WAIT_X.
- Reset asserted mid-run:
  - All handshakes drop immediately.
  - The FSM returns to IDLE and all registers clear.
  - Any partial output is discarded.

## Test plan
- Register access: write 0x14=3, 0x80=1, 0x84=2, 0x88=3; read back each. Required: rdata = 3, 1, 2, 3; each read's rvalid appears 2 cycles after arvalid; ap_ctrl reads 0x4.
- Basic FIR: num_taps=3, coef={1,2,3}, data_length=4, start, then send X = 1,2,3,4 with sm_tready=1. Required: Y = 1, 4, 10, 16; tlast only on 16; ap_ctrl then reads 0x6, and the next read returns 0x4.
- Backpressure: same run with sm_tready held low for 5 cycles on every output. Required: tdata stable while stalled, ss_tready=0 throughout the stall, Y values unchanged.
- Boundaries:
  - num_taps=0 → every Y = 0.
  - num_taps=40 → MAC runs exactly 32 cycles per sample.
  - data_length=0 → one Y, with tlast.
  - coef[0]=0x7FFFFFFF, x=2 → Y=0xFFFFFFFE.
- Busy protection: write coef[0]=9 and ap_start mid-run. Required: bvalid returned, coef[0] and the run unchanged.
- Reset mid-run: assert wb_rst_i during MAC. Required: sm_tvalid=0, ap_ctrl=0x4 and all coef=0 after release; a new run produces correct Y.

Source files
------------

// File: rtl/fir_axis_engine.sv
// FIR engine: AXI-Lite register slave plus an AXI-Stream X-in/Y-out datapath
// built around one sequential MAC that walks the taps one per cycle.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, async active-high reset
//   i_aw*/i_w*/o_b*, i_ar*/o_r*   AXI-Lite slave (ctrl, length, taps, coef)
//   i_ss_*/o_ss_tready            X sample stream in (signed 32-bit)
//   o_sm_*/i_sm_tready            Y sample stream out, tlast on final sample

module fir_axis_engine (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [31:0] i_awaddr,
  input  logic        i_wvalid,
  output logic        o_wready,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_bvalid,
  input  logic        i_bready,
  input  logic        i_arvalid,
  output logic        o_arready,
  input  logic [31:0] i_araddr,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [31:0] o_rdata,
  input  logic        i_ss_tvalid,
  output logic        o_ss_tready,
  input  logic [31:0] i_ss_tdata,
  input  logic        i_ss_tlast,
  output logic        o_sm_tvalid,
  input  logic        i_sm_tready,
  output logic [31:0] o_sm_tdata,
  output logic        o_sm_tlast
);

  localparam int MAX_TAPS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_X,
    S_MAC,
    S_OUT
  } state_t;

  state_t      r_state;

  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic        r_ss_tready;
  logic        r_sm_tvalid;
  logic        r_sm_tlast;
  logic [31:0] r_sm_tdata;

  logic [31:0] r_len;
  logic [31:0] r_taps;
  logic [31:0] r_coef [MAX_TAPS];
  logic [31:0] r_x    [MAX_TAPS];
  logic [31:0] r_acc;
  logic [5:0]  r_k;
  logic [31:0] r_cnt;
  logic        r_done;

  logic        w_wr_fire;
  logic        w_rd_fire;
  logic [7:0]  w_waddr;
  logic [7:0]  w_raddr;
  logic        w_idle;
  logic        w_start;
  logic        w_cfg_we;
  logic        w_wcoef;
  logic        w_rcoef;
  logic [5:0]  w_ntaps;
  logic [31:0] w_len_m1;
  logic        w_last;
  logic        w_mac_end;
  logic [63:0] w_cx;
  logic [63:0] w_xx;
  logic [63:0] w_prod;
  logic [31:0] w_sum;
  logic [31:0] w_rdata;
  logic        w_unused;

  // The address/data phase completes on the cycle the readies are high;
  // the master is still holding address and data at that point.
  assign w_wr_fire = r_awready;
  assign w_rd_fire = r_arready;
  assign w_waddr   = i_awaddr[7:0];
  assign w_raddr   = i_araddr[7:0];
  assign w_idle    = (r_state == S_IDLE);
  assign w_cfg_we  = w_wr_fire && w_idle;
  assign w_start   = w_cfg_we && (w_waddr == 8'h00)
                     && i_wdata[0];
  assign w_wcoef   = w_waddr[7] && (w_waddr[1:0] == 2'b00);
  assign w_rcoef   = w_raddr[7] && (w_raddr[1:0] == 2'b00);

  assign w_ntaps = (r_taps > 32'd32) ? 6'd32
                                     : r_taps[5:0];

  // A length of zero behaves as a single-sample run.
  assign w_len_m1 = (r_len == 32'd0) ? 32'd0
                                     : r_len - 32'd1;
  assign w_last    = (r_cnt == w_len_m1);
  assign w_mac_end = (r_k == w_ntaps - 6'd1);

  assign w_cx = {{32{r_coef[r_k[4:0]][31]}},
                 r_coef[r_k[4:0]]};
  assign w_xx = {{32{r_x[r_k[4:0]][31]}},
                 r_x[r_k[4:0]]};
  assign w_prod = w_cx * w_xx;
  // Accumulator keeps only the low word and wraps.
  assign w_sum  = r_acc + w_prod[31:0];

  assign w_unused = ^{i_wstrb, i_ss_tlast,
                      i_awaddr[31:8], i_araddr[31:8],
                      w_prod[63:32]};

  always_comb begin
    w_rdata = 32'd0;
    unique case (1'b1)
      w_raddr == 8'h00:
        w_rdata = {29'd0, w_idle, r_done, 1'b0};
      w_raddr == 8'h10:
        w_rdata = r_len;
      w_raddr == 8'h14:
        w_rdata = r_taps;
      w_rcoef:
        w_rdata = r_coef[w_raddr[6:2]];
      default:
        w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      if (!r_awready && !r_bvalid
          && i_awvalid && i_wvalid) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end else begin
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
      end

      if (r_awready)
        r_bvalid <= 1'b1;
      else if (i_bready)
        r_bvalid <= 1'b0;

      if (!r_arready && !r_rvalid && i_arvalid)
        r_arready <= 1'b1;
      else
        r_arready <= 1'b0;

      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_len       <= 32'd0;
      r_taps      <= 32'd0;
      r_acc       <= 32'd0;
      r_k         <= 6'd0;
      r_cnt       <= 32'd0;
      r_done      <= 1'b0;
      r_ss_tready <= 1'b0;
      r_sm_tvalid <= 1'b0;
      r_sm_tlast  <= 1'b0;
      r_sm_tdata  <= 32'd0;
      for (int i = 0; i < MAX_TAPS; i++) begin
        r_coef[i] <= 32'd0;
        r_x[i]    <= 32'd0;
      end
    end else begin
      if (w_cfg_we) begin
        unique case (1'b1)
          w_waddr == 8'h10: r_len  <= i_wdata;
          w_waddr == 8'h14: r_taps <= i_wdata;
          w_wcoef: r_coef[w_waddr[6:2]] <= i_wdata;
          default: ;
        endcase
      end

      // Read-to-clear; the FSM below may override.
      if (w_rd_fire && w_raddr == 8'h00)
        r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            for (int i = 0; i < MAX_TAPS; i++)
              r_x[i] <= 32'd0;
            r_cnt       <= 32'd0;
            r_done      <= 1'b0;
            r_ss_tready <= 1'b1;
            r_state     <= S_WAIT_X;
          end
        end

        S_WAIT_X: begin
          if (i_ss_tvalid) begin
            r_x[0] <= i_ss_tdata;
            for (int i = 1; i < MAX_TAPS; i++)
              r_x[i] <= r_x[i-1];
            r_ss_tready <= 1'b0;
            r_acc       <= 32'd0;
            r_k         <= 6'd0;
            if (w_ntaps == 6'd0) begin
              r_sm_tvalid <= 1'b1;
              r_sm_tdata  <= 32'd0;
              r_sm_tlast  <= w_last;
              r_state     <= S_OUT;
            end else begin
              r_state <= S_MAC;
            end
          end
        end

        S_MAC: begin
          r_acc <= w_sum;
          r_k   <= r_k + 6'd1;
          if (w_mac_end) begin
            r_sm_tvalid <= 1'b1;
            r_sm_tdata  <= w_sum;
            r_sm_tlast  <= w_last;
            r_state     <= S_OUT;
          end
        end

        S_OUT: begin
          if (i_sm_tready) begin
            r_sm_tvalid <= 1'b0;
            r_sm_tlast  <= 1'b0;
            if (r_sm_tlast) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt       <= r_cnt + 32'd1;
              r_ss_tready <= 1'b1;
              r_state     <= S_WAIT_X;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_awready   = r_awready;
  assign o_wready    = r_wready;
  assign o_bvalid    = r_bvalid;
  assign o_arready   = r_arready;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_ss_tready = r_ss_tready;
  assign o_sm_tvalid = r_sm_tvalid;
  assign o_sm_tdata  = r_sm_tdata;
  assign o_sm_tlast  = r_sm_tlast;

endmodule

// File: tb/tb_fir_axis_engine.sv
// Bench for fir_axis_engine: directed register/stream steps with random
// coefficients and samples checked against a plain-arithmetic FIR model.

module tb_fir_axis_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 4'hF;
  logic        bvalid, bready = 0;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic        ss_tvalid = 0, ss_tready;
  logic [31:0] ss_tdata = 0;
  logic        ss_tlast = 0;
  logic        sm_tvalid, sm_tready = 0;
  logic [31:0] sm_tdata;
  logic        sm_tlast;

  int n_tests = 0;
  int n_fail  = 0;
  int m_coef [32];
  int xs [$];

  fir_axis_engine dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .i_awvalid  (awvalid),
    .o_awready  (awready),
    .i_awaddr   (awaddr),
    .i_wvalid   (wvalid),
    .o_wready   (wready),
    .i_wdata    (wdata),
    .i_wstrb    (wstrb),
    .o_bvalid   (bvalid),
    .i_bready   (bready),
    .i_arvalid  (arvalid),
    .o_arready  (arready),
    .i_araddr   (araddr),
    .o_rvalid   (rvalid),
    .i_rready   (rready),
    .o_rdata    (rdata),
    .i_ss_tvalid(ss_tvalid),
    .o_ss_tready(ss_tready),
    .i_ss_tdata (ss_tdata),
    .i_ss_tlast (ss_tlast),
    .o_sm_tvalid(sm_tvalid),
    .i_sm_tready(sm_tready),
    .o_sm_tdata (sm_tdata),
    .o_sm_tlast (sm_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // y[n] = sum over k < min(taps,32) of coef[k] * x[n-k], low 32 bits.
  function automatic logic [31:0] model(input int n,
                                        input int ntaps);
    longint s;
    int eff;
    s = 0;
    eff = (ntaps > 32) ? 32 : ntaps;
    for (int k = 0; k < eff; k++)
      if (n - k >= 0)
        s += longint'(m_coef[k]) * longint'(xs[n-k]);
    return s[31:0];
  endfunction

  task automatic axi_write(input logic [7:0] a,
                           input logic [31:0] d);
    int n;
    @(negedge clk);
    awaddr = {24'd0, a};
    wdata = d;
    awvalid = 1;
    wvalid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!awready && n < 20);
    check("awready", 32'(awready), 32'd1);
    check("wready", 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 0;
    wvalid = 0;
    check("bvalid", 32'(bvalid), 32'd1);
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a,
                          output logic [31:0] d,
                          output int lat);
    @(negedge clk);
    araddr = {24'd0, a};
    arvalid = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rvalid && lat < 20);
    arvalid = 0;
    check("rvalid", 32'(rvalid), 32'd1);
    d = rdata;
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic read_chk(input string tag,
                          input logic [7:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    axi_read(a, d, lat);
    check(tag, d, exp);
  endtask

  task automatic wr_coef(input int k, input int v);
    m_coef[k] = v;
    axi_write(8'(128 + 4 * k), v);
  endtask

  task automatic send_x(input logic [31:0] x);
    int n;
    @(negedge clk);
    ss_tdata = x;
    ss_tvalid = 1;
    n = 0;
    while (!ss_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ss_tready", 32'(ss_tready), 32'd1);
    @(negedge clk);
    ss_tvalid = 0;
  endtask

  task automatic run_stream(input int nsamp,
                            input int ntaps,
                            input int stall,
                            input bit chk_lat);
    int lat;
    int eff;
    logic [31:0] d0;
    logic l0;
    bit stable;
    eff = (ntaps > 32) ? 32 : ntaps;
    for (int n = 0; n < nsamp; n++) begin
      send_x(xs[n]);
      lat = 1;
      while (!sm_tvalid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("y%0d_tvalid", n),
            32'(sm_tvalid), 32'd1);
      if (chk_lat)
        check($sformatf("y%0d_latency", n),
              lat, eff + 1);
      d0 = sm_tdata;
      l0 = sm_tlast;
      stable = 1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (sm_tdata !== d0 || sm_tlast !== l0 ||
            sm_tvalid !== 1'b1 || ss_tready !== 1'b0)
          stable = 0;
      end
      if (stall > 0)
        check($sformatf("y%0d_stall", n),
              32'(stable), 32'd1);
      check($sformatf("y%0d_data", n),
            d0, model(n, ntaps));
      check($sformatf("y%0d_tlast", n),
            32'(l0), 32'(n == nsamp - 1));
      sm_tready = 1;
      @(negedge clk);
      sm_tready = 0;
      check($sformatf("y%0d_drop", n),
            32'(sm_tvalid), 32'd0);
    end
  endtask

  task automatic rand_xs(input int n);
    xs = {};
    for (int i = 0; i < n; i++)
      xs.push_back(int'($urandom));
  endtask

  initial begin
    logic [31:0] d;
    int lat;

    for (int k = 0; k < 32; k++)
      m_coef[k] = 0;

    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_ss_tready", 32'(ss_tready), 32'd0);
    check("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check("rst_sm_tdata", sm_tdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 0;
    @(negedge clk);
    check("idle_bvalid", 32'(bvalid), 32'd0);
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_sm_tlast", 32'(sm_tlast), 32'd0);
    read_chk("rst_ctrl", 8'h00, 32'h4);
    read_chk("rst_taps", 8'h14, 32'h0);

    // register access and read latency
    axi_write(8'h14, 3);
    wr_coef(0, 1);
    wr_coef(1, 2);
    wr_coef(2, 3);
    axi_read(8'h14, d, lat);
    check("reg_taps", d, 32'd3);
    check("reg_lat_taps", lat, 32'd2);
    axi_read(8'h80, d, lat);
    check("reg_c0", d, 32'd1);
    check("reg_lat_c0", lat, 32'd2);
    axi_read(8'h84, d, lat);
    check("reg_c1", d, 32'd2);
    axi_read(8'h88, d, lat);
    check("reg_c2", d, 32'd3);
    check("reg_lat_c2", lat, 32'd2);
    read_chk("reg_ctrl", 8'h00, 32'h4);
    read_chk("reg_unmapped", 8'h40, 32'h0);

    // basic FIR
    axi_write(8'h10, 4);
    xs = {1, 2, 3, 4};
    axi_write(8'h00, 1);
    read_chk("busy_ctrl", 8'h00, 32'h0);
    run_stream(4, 3, 0, 1);
    read_chk("done_ctrl", 8'h00, 32'h6);
    read_chk("done_clr", 8'h00, 32'h4);

    // backpressure
    axi_write(8'h00, 1);
    run_stream(4, 3, 5, 1);
    read_chk("bp_ctrl", 8'h00, 32'h6);

    // random coefficients and samples
    for (int k = 0; k < 5; k++)
      wr_coef(k, int'($urandom));
    axi_write(8'h14, 5);
    axi_write(8'h10, 6);
    rand_xs(6);
    axi_write(8'h00, 1);
    run_stream(6, 5, 2, 1);

    // zero taps
    axi_write(8'h14, 0);
    axi_write(8'h10, 3);
    rand_xs(3);
    axi_write(8'h00, 1);
    run_stream(3, 0, 0, 1);

    // taps beyond the array clamp to 32
    for (int k = 0; k < 32; k++)
      wr_coef(k, int'($urandom));
    axi_write(8'h14, 40);
    rand_xs(3);
    axi_write(8'h00, 1);
    run_stream(3, 40, 0, 1);

    // zero length behaves as one sample
    axi_write(8'h14, 3);
    axi_write(8'h10, 0);
    rand_xs(1);
    axi_write(8'h00, 1);
    run_stream(1, 3, 0, 1);
    read_chk("len0_ctrl", 8'h00, 32'h6);

    // wrap instead of saturate
    axi_write(8'h14, 1);
    axi_write(8'h10, 1);
    wr_coef(0, 32'h7FFFFFFF);
    xs = {2};
    axi_write(8'h00, 1);
    run_stream(1, 1, 0, 1);

    // writes and start while busy are dropped
    wr_coef(0, 1);
    wr_coef(1, 2);
    wr_coef(2, 3);
    axi_write(8'h14, 3);
    axi_write(8'h10, 2);
    rand_xs(2);
    axi_write(8'h00, 1);
    axi_write(8'h80, 9);
    axi_write(8'h00, 1);
    axi_write(8'h14, 7);
    read_chk("busy_c0", 8'h80, 32'd1);
    read_chk("busy_taps", 8'h14, 32'd3);
    run_stream(2, 3, 0, 1);
    read_chk("busy_done", 8'h00, 32'h6);

    // reset in the middle of a MAC pass
    for (int k = 0; k < 32; k++)
      wr_coef(k, int'($urandom));
    axi_write(8'h14, 40);
    axi_write(8'h10, 4);
    axi_write(8'h00, 1);
    send_x(32'd5);
    repeat (3) @(negedge clk);
    check("mid_busy_tvalid", 32'(sm_tvalid), 32'd0);
    rst = 1;
    #1;
    check("mrst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check("mrst_ss_tready", 32'(ss_tready), 32'd0);
    check("mrst_sm_tdata", sm_tdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 32; k++)
      m_coef[k] = 0;
    @(negedge clk);
    check("post_sm_tvalid", 32'(sm_tvalid), 32'd0);
    read_chk("post_ctrl", 8'h00, 32'h4);
    read_chk("post_taps", 8'h14, 32'h0);
    read_chk("post_len", 8'h10, 32'h0);
    for (int k = 0; k < 32; k++)
      read_chk($sformatf("post_c%0d", k),
               8'(128 + 4 * k), 32'd0);
    for (int k = 0; k < 3; k++)
      wr_coef(k, int'($urandom));
    axi_write(8'h14, 3);
    axi_write(8'h10, 3);
    rand_xs(3);
    axi_write(8'h00, 1);
    run_stream(3, 3, 1, 1);
    read_chk("post_done", 8'h00, 32'h6);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
